// File: rtl/key_encoder83.sv
// Active-low key bank front end: two-flop synchroniser, whole-vector debounce,
// and a press/release FSM that priority-encodes a newly pressed key into a 3-bit code.
module key_encoder83 #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19
) (
  input  logic       clk_in,
  input  logic       btn_rst,
  input  logic [7:0] key_n,
  output logic [2:0] code,
  output logic       code_valid,
  output logic       multi_err,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  logic [7:0]       sync1_q;
  logic [7:0]       sync2_q;
  logic [7:0]       sync_pressed;
  logic [7:0]       cand_q;
  logic [7:0]       cand_d;
  logic [7:0]       deb_q;
  logic [7:0]       deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       code_q;
  logic [2:0]       code_d;
  logic             code_valid_q;
  logic             code_valid_d;
  logic             multi_err_q;
  logic             multi_err_d;

  logic [2:0]       hi_idx;
  logic [3:0]       ones;

  // Reset to the released level so a key held through reset reads as a fresh press.
  always_ff @(posedge clk_in or posedge btn_rst) begin
    if (btn_rst) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign sync_pressed = ~sync2_q;

  // Any change in the vector restarts the stability count; deb only moves once the count saturates.
  always_comb begin
    cand_d = cand_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if (sync_pressed != cand_q) begin
      cand_d = sync_pressed;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge btn_rst) begin
    if (btn_rst) begin
      cand_q <= 8'hFF;
      deb_q  <= 8'h00;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    hi_idx = 3'd0;
    ones   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (deb_q[i]) begin
        hi_idx = 3'(i);
      end
      ones = ones + {3'b000, deb_q[i]};
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    multi_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (deb_q != 8'h00) begin
          code_d  = hi_idx;
          state_d = HELD;
          if (ones == 4'd1) begin
            code_valid_d = 1'b1;
          end else begin
            multi_err_d = 1'b1;
          end
        end
      end
      HELD: begin
        if (deb_q == 8'h00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge btn_rst) begin
    if (btn_rst) begin
      state_q      <= IDLE;
      code_q       <= 3'd0;
      code_valid_q <= 1'b0;
      multi_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      multi_err_q  <= multi_err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign multi_err  = multi_err_q;
  assign key_held   = (state_q == HELD);

endmodule
